// File: rtl/ex_mem_pipe_pkg.sv
// ex_mem_pipe_pkg: shared constants, transfer-mode encoding and the stall/flush priority decode.
// Used by ex_mem_pipe and ex_mem_carry.
package ex_mem_pipe_pkg;

    localparam logic        RstEnable    = 1'b0;
    localparam logic        Stop         = 1'b1;
    localparam logic        NoStop       = 1'b0;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr   = 5'b00000;
    localparam int          StallBusW    = 6;
    localparam int          StageEx      = 3;
    localparam int          StageMem     = 4;

    typedef enum logic [1:0] {
        XFER_FLUSH,
        XFER_PASS,
        XFER_BUBBLE,
        XFER_HOLD
    } xfer_e;

    // Flush beats every stall; an illegal "EX runs, MEM stops" pattern falls into PASS.
    function automatic xfer_e xfer_decode(input logic flush, input logic ex_stop, input logic mem_stop);
        return flush ? XFER_FLUSH :
               (ex_stop != Stop) ? XFER_PASS :
               (mem_stop != Stop) ? XFER_BUBBLE : XFER_HOLD;
    endfunction

endpackage

// File: rtl/ex_mem_carry.sv
// ex_mem_carry: holds the madd/msub accumulator temp and cycle count for EX across stalls.
// Ports: clk, rst (async active-low), clr (zero the carry), load (capture hilo_i/count_i),
//        hilo_i/count_i from EX, hilo_o/count_o back to EX.
module ex_mem_carry
    import ex_mem_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  load,
    input  logic [2*DATA_W-1:0]   hilo_i,
    input  logic [CNT_W-1:0]      count_i,
    output logic [2*DATA_W-1:0]   hilo_o,
    output logic [CNT_W-1:0]      count_o
);

    logic [2*DATA_W-1:0] r_hilo;
    logic [CNT_W-1:0]    r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            r_hilo  <= '0;
            r_count <= '0;
        end else if (clr) begin
            r_hilo  <= '0;
            r_count <= '0;
        end else if (load) begin
            r_hilo  <= hilo_i;
            r_count <= count_i;
        end
    end

    assign hilo_o  = r_hilo;
    assign count_o = r_count;

endmodule

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX->MEM pipeline register with stall/flush handling and madd/msub carry.
// Ports: clk, rst (async active-low), stall vector, flush, ex_* payload in, mem_* payload out,
//        hilo_i/count_i carry in, hilo_o/count_o carry out.
// Optional EX_MEM_STATS_EN: adds saturating bubble_cnt/hold_cnt outputs.
module ex_mem_pipe
    import ex_mem_pipe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ALUOP_W = 8,
    parameter int CNT_W   = 2,
    parameter int STALL_W = StallBusW,
    parameter int STAGE   = StageEx
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
    input  logic                  flush,
    input  logic                  ex_valid,
    input  logic                  ex_wReg,
    input  logic [ADDR_W-1:0]     ex_wAddr,
    input  logic [DATA_W-1:0]     ex_wData,
    input  logic                  ex_wHiLo,
    input  logic [DATA_W-1:0]     ex_hiData,
    input  logic [DATA_W-1:0]     ex_loData,
    input  logic [ALUOP_W-1:0]    ex_aluop,
    input  logic [DATA_W-1:0]     ex_memAddr,
    input  logic [DATA_W-1:0]     ex_storeData,
    input  logic [2*DATA_W-1:0]   hilo_i,
    input  logic [CNT_W-1:0]      count_i,
    output logic                  mem_valid,
    output logic                  mem_wReg,
    output logic [ADDR_W-1:0]     mem_wAddr,
    output logic [DATA_W-1:0]     mem_wData,
    output logic                  mem_wHiLo,
    output logic [DATA_W-1:0]     mem_hiData,
    output logic [DATA_W-1:0]     mem_loData,
    output logic [ALUOP_W-1:0]    mem_aluop,
    output logic [DATA_W-1:0]     mem_memAddr,
    output logic [DATA_W-1:0]     mem_storeData,
    output logic [2*DATA_W-1:0]   hilo_o,
    output logic [CNT_W-1:0]      count_o
`ifdef EX_MEM_STATS_EN
    ,
    output logic [31:0]           bubble_cnt,
    output logic [31:0]           hold_cnt
`endif
);

    xfer_e w_xfer;

    logic                r_valid;
    logic                r_wReg;
    logic [ADDR_W-1:0]   r_wAddr;
    logic [DATA_W-1:0]   r_wData;
    logic                r_wHiLo;
    logic [DATA_W-1:0]   r_hiData;
    logic [DATA_W-1:0]   r_loData;
    logic [ALUOP_W-1:0]  r_aluop;
    logic [DATA_W-1:0]   r_memAddr;
    logic [DATA_W-1:0]   r_storeData;

    assign w_xfer = xfer_decode(flush, stall[STAGE], stall[STAGE+1]);

    // Flush and bubble both load an all-zero entry, so a bubble can never write.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            r_valid     <= 1'b0;
            r_wReg      <= WriteDisable;
            r_wAddr     <= '0;
            r_wData     <= '0;
            r_wHiLo     <= WriteDisable;
            r_hiData    <= '0;
            r_loData    <= '0;
            r_aluop     <= '0;
            r_memAddr   <= '0;
            r_storeData <= '0;
        end else if (w_xfer == XFER_PASS) begin
            r_valid     <= ex_valid;
            r_wReg      <= ex_wReg;
            r_wAddr     <= ex_wAddr;
            r_wData     <= ex_wData;
            r_wHiLo     <= ex_wHiLo;
            r_hiData    <= ex_hiData;
            r_loData    <= ex_loData;
            r_aluop     <= ex_aluop;
            r_memAddr   <= ex_memAddr;
            r_storeData <= ex_storeData;
        end else if (w_xfer != XFER_HOLD) begin
            r_valid     <= 1'b0;
            r_wReg      <= WriteDisable;
            r_wAddr     <= '0;
            r_wData     <= '0;
            r_wHiLo     <= WriteDisable;
            r_hiData    <= '0;
            r_loData    <= '0;
            r_aluop     <= '0;
            r_memAddr   <= '0;
            r_storeData <= '0;
        end
    end

    assign mem_valid     = r_valid;
    assign mem_wReg      = r_wReg;
    assign mem_wAddr     = r_wAddr;
    assign mem_wData     = r_wData;
    assign mem_wHiLo     = r_wHiLo;
    assign mem_hiData    = r_hiData;
    assign mem_loData    = r_loData;
    assign mem_aluop     = r_aluop;
    assign mem_memAddr   = r_memAddr;
    assign mem_storeData = r_storeData;

    // Carry survives only while EX is frozen; any flush or EX advance ends the multi-cycle op.
    ex_mem_carry #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_carry (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_xfer == XFER_FLUSH || w_xfer == XFER_PASS),
        .load    (w_xfer == XFER_BUBBLE || w_xfer == XFER_HOLD),
        .hilo_i  (hilo_i),
        .count_i (count_i),
        .hilo_o  (hilo_o),
        .count_o (count_o)
    );

`ifdef EX_MEM_STATS_EN
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_hold_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            r_bubble_cnt <= '0;
            r_hold_cnt   <= '0;
        end else begin
            if (w_xfer == XFER_BUBBLE && r_bubble_cnt != 32'hFFFF_FFFF)
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            if (w_xfer == XFER_HOLD && r_hold_cnt != 32'hFFFF_FFFF)
                r_hold_cnt <= r_hold_cnt + 32'd1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign hold_cnt   = r_hold_cnt;
`endif

    // The stall vector is monotone: MEM cannot stop while EX runs.
    a_stall_monotone: assert property (@(posedge clk) disable iff (rst == RstEnable)
        !(stall[STAGE] == NoStop && stall[STAGE+1] == Stop));

endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb_ex_mem_pipe: directed self-checking bench for ex_mem_pipe.
module tb_ex_mem_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = '0;
    logic        flush = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_wReg = 1'b0;
    logic [4:0]  ex_wAddr = '0;
    logic [31:0] ex_wData = '0;
    logic        ex_wHiLo = 1'b0;
    logic [31:0] ex_hiData = '0;
    logic [31:0] ex_loData = '0;
    logic [7:0]  ex_aluop = '0;
    logic [31:0] ex_memAddr = '0;
    logic [31:0] ex_storeData = '0;
    logic [63:0] hilo_i = '0;
    logic [1:0]  count_i = '0;
    logic        mem_valid;
    logic        mem_wReg;
    logic [4:0]  mem_wAddr;
    logic [31:0] mem_wData;
    logic        mem_wHiLo;
    logic [31:0] mem_hiData;
    logic [31:0] mem_loData;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_memAddr;
    logic [31:0] mem_storeData;
    logic [63:0] hilo_o;
    logic [1:0]  count_o;
`ifdef EX_MEM_STATS_EN
    logic [31:0] bubble_cnt;
    logic [31:0] hold_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ex_mem_pipe dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_wReg       (ex_wReg),
        .ex_wAddr      (ex_wAddr),
        .ex_wData      (ex_wData),
        .ex_wHiLo      (ex_wHiLo),
        .ex_hiData     (ex_hiData),
        .ex_loData     (ex_loData),
        .ex_aluop      (ex_aluop),
        .ex_memAddr    (ex_memAddr),
        .ex_storeData  (ex_storeData),
        .hilo_i        (hilo_i),
        .count_i       (count_i),
        .mem_valid     (mem_valid),
        .mem_wReg      (mem_wReg),
        .mem_wAddr     (mem_wAddr),
        .mem_wData     (mem_wData),
        .mem_wHiLo     (mem_wHiLo),
        .mem_hiData    (mem_hiData),
        .mem_loData    (mem_loData),
        .mem_aluop     (mem_aluop),
        .mem_memAddr   (mem_memAddr),
        .mem_storeData (mem_storeData),
        .hilo_o        (hilo_o),
        .count_o       (count_o)
`ifdef EX_MEM_STATS_EN
        ,
        .bubble_cnt    (bubble_cnt),
        .hold_cnt      (hold_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One rising edge, then return on the following falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_all(input logic [31:0] v);
        ex_valid     = v[0];
        ex_wReg      = v[1];
        ex_wAddr     = v[4:0];
        ex_wData     = v;
        ex_wHiLo     = v[2];
        ex_hiData    = v;
        ex_loData    = v;
        ex_aluop     = v[7:0];
        ex_memAddr   = v;
        ex_storeData = v;
        hilo_i       = {v, v};
        count_i      = v[1:0];
    endtask

    initial begin
        #1;
        chk("rst_valid", 64'(mem_valid), 64'd0);
        chk("rst_wdata", 64'(mem_wData), 64'd0);
        chk("rst_hilo", hilo_o, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // pass-through
        stall = 6'b000000;
        ex_valid = 1'b1; ex_wReg = 1'b1; ex_wAddr = 5'd5; ex_wData = 32'h1234_5678;
        ex_wHiLo = 1'b1; ex_hiData = 32'h0000_0011; ex_loData = 32'h0000_0022;
        ex_aluop = 8'h8C; ex_memAddr = 32'h0000_1000; ex_storeData = 32'h0000_DEAD;
        hilo_i = 64'hDEAD_BEEF_0BAD_F00D; count_i = 2'd3;
        step();
        chk("pass_valid", 64'(mem_valid), 64'd1);
        chk("pass_wreg", 64'(mem_wReg), 64'd1);
        chk("pass_waddr", 64'(mem_wAddr), 64'd5);
        chk("pass_wdata", 64'(mem_wData), 64'h1234_5678);
        chk("pass_whilo", 64'(mem_wHiLo), 64'd1);
        chk("pass_hi", 64'(mem_hiData), 64'h11);
        chk("pass_lo", 64'(mem_loData), 64'h22);
        chk("pass_aluop", 64'(mem_aluop), 64'h8C);
        chk("pass_maddr", 64'(mem_memAddr), 64'h1000);
        chk("pass_sdata", 64'(mem_storeData), 64'hDEAD);
        chk("pass_hilo", hilo_o, 64'd0);
        chk("pass_count", 64'(count_o), 64'd0);

        // madd stall: EX frozen, MEM advances with a bubble
        stall = 6'b001111; hilo_i = 64'h0000_0001_0000_0002; count_i = 2'd1;
        step();
        chk("madd_valid", 64'(mem_valid), 64'd0);
        chk("madd_wreg", 64'(mem_wReg), 64'd0);
        chk("madd_whilo", 64'(mem_wHiLo), 64'd0);
        chk("madd_wdata", 64'(mem_wData), 64'd0);
        chk("madd_hilo", hilo_o, 64'h0000_0001_0000_0002);
        chk("madd_count", 64'(count_o), 64'd1);
        hilo_i = 64'h0000_0003_0000_0004; count_i = 2'd2;
        step();
        chk("madd2_hilo", hilo_o, 64'h0000_0003_0000_0004);
        chk("madd2_count", 64'(count_o), 64'd2);
        stall = 6'b000000; ex_wData = 32'hCAFE_BABE;
        step();
        chk("madd_end_valid", 64'(mem_valid), 64'd1);
        chk("madd_end_wdata", 64'(mem_wData), 64'hCAFE_BABE);
        chk("madd_end_hilo", hilo_o, 64'd0);
        chk("madd_end_count", 64'(count_o), 64'd0);

        // full hold
        ex_wData = 32'hA5A5_A5A5;
        step();
        stall = 6'b011111;
        for (int i = 1; i <= 3; i++) begin
            ex_wData = 32'(i) * 32'h1111_1111;
            ex_wReg = 1'b0;
            hilo_i = {32'(i), 32'h5000_0000 + 32'(i)};
            count_i = 2'(i);
            step();
            chk("hold_wdata", 64'(mem_wData), 64'hA5A5_A5A5);
            chk("hold_valid", 64'(mem_valid), 64'd1);
            chk("hold_wreg", 64'(mem_wReg), 64'd1);
            chk("hold_hilo", hilo_o, {32'(i), 32'h5000_0000 + 32'(i)});
            chk("hold_count", 64'(count_o), 64'(i));
        end

        // flush overrides the full stall
        flush = 1'b1; count_i = 2'd2;
        step();
        flush = 1'b0;
        chk("flush_valid", 64'(mem_valid), 64'd0);
        chk("flush_wreg", 64'(mem_wReg), 64'd0);
        chk("flush_wdata", 64'(mem_wData), 64'd0);
        chk("flush_count", 64'(count_o), 64'd0);
        chk("flush_hilo", hilo_o, 64'd0);

        // async reset with all-ones payload and carry loaded
        stall = 6'b000000;
        drive_all(32'hFFFF_FFFF);
        step();
        chk("ones_wdata", 64'(mem_wData), 64'hFFFF_FFFF);
        stall = 6'b011111;
        step();
        chk("ones_hilo", hilo_o, 64'hFFFF_FFFF_FFFF_FFFF);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", 64'(mem_valid), 64'd0);
        chk("arst_wreg", 64'(mem_wReg), 64'd0);
        chk("arst_waddr", 64'(mem_wAddr), 64'd0);
        chk("arst_wdata", 64'(mem_wData), 64'd0);
        chk("arst_sdata", 64'(mem_storeData), 64'd0);
        chk("arst_hilo", hilo_o, 64'd0);
        chk("arst_count", 64'(count_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        drive_all(32'h0);

`ifdef EX_MEM_STATS_EN
        chk("stat_rst_bub", 64'(bubble_cnt), 64'd0);
        chk("stat_rst_hold", 64'(hold_cnt), 64'd0);
        stall = 6'b001111;
        for (int i = 0; i < 4; i++) step();
        stall = 6'b011111;
        for (int i = 0; i < 2; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("stat_bub", 64'(bubble_cnt), 64'd4);
        chk("stat_hold", 64'(hold_cnt), 64'd2);
        force dut.r_bubble_cnt = 32'hFFFF_FFFF;
        #1 release dut.r_bubble_cnt;
        stall = 6'b001111;
        step();
        chk("stat_sat", 64'(bubble_cnt), 64'hFFFF_FFFF);
        stall = 6'b000000;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
Parametrised EX→MEM pipeline register. It carries the register-write, HI/LO-write and memory-op fields from EX into MEM. It honours the 6-bit stall vector, flushes on exceptions, and keeps a per-entry valid bit. It also holds the multi-cycle accumulator carry (hilo temp and cycle count) that EX needs for madd/msub while the pipe is stalled.

Parameters:
DATA_W, 32, width of register/HI/LO/memory data
ADDR_W, 5, register-file address width
ALUOP_W, 8, aluop field width forwarded to MEM
CNT_W, 2, multi-cycle count width
STALL_W, 6, stall vector width
STAGE, 3, stall-vector bit owned by EX; bit STAGE+1 is MEM

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
stall  in  STALL_W  stall vector, 1 = Stop
flush  in  1  discard EX→MEM transfer (exception)
ex_valid  in  1  EX holds a real instruction
ex_wReg  in  1  GPR write enable
ex_wAddr  in  ADDR_W  GPR write address
ex_wData  in  DATA_W  GPR write data
ex_wHiLo  in  1  HI/LO write enable
ex_hiData, ex_loData  in  DATA_W each  HI/LO data
ex_aluop  in  ALUOP_W  op code for MEM
ex_memAddr  in  DATA_W  load/store address
ex_storeData  in  DATA_W  store data
hilo_i  in  2*DATA_W  accumulator temp from EX
count_i  in  CNT_W  multi-cycle count from EX
mem_valid  out  1
mem_wReg, mem_wAddr, mem_wData, mem_wHiLo, mem_hiData, mem_loData, mem_aluop, mem_memAddr, mem_storeData  out  matching widths
hilo_o  out  2*DATA_W  accumulator temp back to EX
count_o  out  CNT_W  count back to EX

Behaviour:
- All outputs are registered. Latency is 1 clk.
- rst=0, asynchronous: every output goes to 0. mem_wAddr = NOP address (0). hilo_o = 0, count_o = 0.
- Per rising edge, in priority order:
  1. flush=1: load a bubble (all mem_* = 0, mem_valid=0). hilo_o=0, count_o=0. Flush overrides any stall.
  2. stall[STAGE]=0: capture all ex_* into mem_*, with mem_valid=ex_valid. hilo_o=0, count_o=0, because the multi-cycle op finished or never started.
  3. stall[STAGE]=1, stall[STAGE+1]=0: EX frozen, MEM advances. Insert a bubble (mem_* = 0, mem_valid=0). hilo_o←hilo_i, count_o←count_i.
  4. stall[STAGE]=1, stall[STAGE+1]=1: hold all mem_*. hilo_o←hilo_i, count_o←count_i.
- The stall vector is guaranteed monotone (a set bit implies all lower bits are set). The case stall[STAGE]=0 with stall[STAGE+1]=1 is illegal. The block treats it as case 2; assertion-only check.
- The count carry is stored as given, with no arithmetic. Wrap of count_i is EX's concern.
- A bubble must never write: mem_wReg=0 and mem_wHiLo=0 whenever mem_valid=0.
- Reset mid multi-cycle op: carry is cleared immediately and asynchronously. No recovery.

Optional Feature:
EX_MEM_STATS_EN
- Defined: adds outputs bubble_cnt[31:0] and hold_cnt[31:0].
  - bubble_cnt increments on every case-3 edge.
  - hold_cnt increments on every case-4 edge.
  - Both saturate at 0xFFFFFFFF, clear on rst, and are not cleared by flush.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- Shared defines file:
  - RstEnable now 1'b0 for this block family
  - Stop=1'b1, NoStop
  - WriteEnable/WriteDisable
  - ZeroWord, NOPRegAddr
  - StallSignal width
  - EX/MEM stage index constants
- One sub-module, ex_mem_carry: holds hilo_o/count_o with clear/load controls (clear in cases 1–2, load in 3–4). The top-level contains only the payload register and the priority decode.

Test Plan:
- Reset: rst=0 mid-run with all ex_* = 0xFFFFFFFF → all outputs 0 asynchronously, before the next clk.
- Pass-through: stall=0, ex_wReg=1, ex_wAddr=5, ex_wData=0x12345678, ex_valid=1 → next edge mem_* match and mem_valid=1; hilo_o=0, count_o=0.
- Madd stall: stall=6'b001111, hilo_i=0x00000001_00000002, count_i=1 → mem_valid=0, mem_wReg=0; hilo_o=0x00000001_00000002, count_o=1. Then stall=0 → capture EX and carry returns to 0.
- Full hold: load wData=0xA5A5A5A5, then stall=6'b011111 for 3 cycles with changing ex_* → mem_wData stays 0xA5A5A5A5; carry tracks hilo_i each cycle.
- Flush priority: flush=1 with stall=6'b011111 and count_i=2 → mem_valid=0, mem_wReg=0, count_o=0.
- Stats (EX_MEM_STATS_EN): 4 case-3 edges and 2 case-4 edges → bubble_cnt=4, hold_cnt=2. Preloading 0xFFFFFFFF via force shows saturation.
